upsampler_l: RTL and testbench

UPSAMPLER_L -- requirements
Module: upsampler_l

---
 rtl/upsampler_l.sv | 107 ++++++++++
 tb/tb_upsampler_l.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/upsampler_l.sv
`default_nettype none
// ============================================================================
//  Module      : upsampler_l
//  Description : Streaming integer upsampler by runtime factor L; each input
//                beat becomes L output beats (sample-and-hold or zero-stuff).
//  Revision    : 1.0 - initial release
// ============================================================================
module upsampler_l #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2,
    parameter int FW       = 4,
    parameter int MODE     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FW-1:0]             factor,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*CHANNELS-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*CHANNELS-1:0] out_data,
    output logic [FW-1:0]             out_phase,
    output logic                      out_last
);

    localparam int            c_DW  = WIDTH * CHANNELS;
    localparam logic [FW-1:0] c_ONE = {{(FW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [FW-1:0]   r_ph, w_ph_nxt;
    logic [FW-1:0]   r_last_ph, w_last_ph_nxt;
    logic [c_DW-1:0] r_data, w_data_nxt;
    logic [c_DW-1:0] w_fill;
    logic [FW-1:0]   w_factor_last;
    logic            w_at_last;
    logic            w_in_ready;
    logic            w_in_fire;

    // Factor 0 behaves as L = 1, so its last phase index is 0 as well.
    assign w_factor_last = (factor == '0) ? '0 : (factor - c_ONE);
    assign w_at_last     = (r_ph == r_last_ph);
    assign w_in_ready    = !rst && ((r_state == S_IDLE) || (w_at_last && out_ready));
    assign w_in_fire     = in_valid && w_in_ready;

    generate
        if (MODE == 1) begin : g_zero_fill
            assign w_fill = '0;
        end else begin : g_hold_fill
            assign w_fill = r_data;
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_ph_nxt      = r_ph;
        w_last_ph_nxt = r_last_ph;
        w_data_nxt    = r_data;
        if (r_state == S_IDLE) begin
            if (w_in_fire) begin
                w_state_nxt   = S_EMIT;
                w_ph_nxt      = '0;
                w_last_ph_nxt = w_factor_last;
                w_data_nxt    = in_data;
            end
        end else if (out_ready) begin
            if (!w_at_last) begin
                w_ph_nxt   = r_ph + c_ONE;
                w_data_nxt = w_fill;
            end else if (w_in_fire) begin
                w_ph_nxt      = '0;
                w_last_ph_nxt = w_factor_last;
                w_data_nxt    = in_data;
            end else begin
                w_state_nxt = S_IDLE;
                w_ph_nxt    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ph      <= '0;
            r_last_ph <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ph      <= w_ph_nxt;
            r_last_ph <= w_last_ph_nxt;
            r_data    <= w_data_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == S_EMIT);
    assign out_data  = r_data;
    assign out_phase = out_valid ? r_ph : '0;
    assign out_last  = out_valid && w_at_last;

endmodule
`default_nettype wire

// File: tb/tb_upsampler_l.sv
`default_nettype none
// ============================================================================
//  Module      : tb_upsampler_l
//  Description : Directed and scoreboard bench for upsampler_l, MODE 0 and 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_upsampler_l;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  factor;
    logic        in_valid;
    logic [23:0] in_data;
    logic        out_ready;
    logic        rdy0, rdy1, v0, v1, l0, l1;
    logic [23:0] d0, d1;
    logic [3:0]  p0, p1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    upsampler_l #(.WIDTH(12), .CHANNELS(2), .FW(4), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .factor(factor), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .out_valid(v0), .out_ready(out_ready), .out_data(d0),
        .out_phase(p0), .out_last(l0)
    );

    upsampler_l #(.WIDTH(12), .CHANNELS(2), .FW(4), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .factor(factor), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .out_valid(v1), .out_ready(out_ready), .out_data(d1),
        .out_phase(p1), .out_last(l1)
    );

    function automatic logic [31:0] pk(input logic v, input logic [23:0] d,
                                       input logic [3:0] p, input logic l);
        return {2'b00, v, d, p, l};
    endfunction

    function automatic logic [31:0] b1(input logic x);
        return {31'd0, x};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%08h exp=%08h", tag, act, exp);
        end
    endtask

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] head;
    int          sent, beats0, beats1, exp_beats, cyc;
    int          lval;

    initial begin
        rst = 1'b1; factor = 4'd0; in_valid = 1'b0; in_data = 24'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out0", pk(v0, d0, p0, l0), 32'd0);
        chk("rst_out1", pk(v1, d1, p1, l1), 32'd0);
        chk("rst_rdy", b1(rdy0), b1(1'b0));
        rst = 1'b0;

        // Single beat, factor 4
        @(negedge clk);
        factor = 4'd4; in_data = 24'hABC123; in_valid = 1'b1;
        #1 chk("t1_rdy", b1(rdy1), b1(1'b1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0; factor = 4'd0;
            chk("t1_m1", pk(v1, d1, p1, l1),
                pk(1'b1, (i == 0) ? 24'hABC123 : 24'd0, 4'(i), i == 3));
            chk("t1_m0", pk(v0, d0, p0, l0), pk(1'b1, 24'hABC123, 4'(i), i == 3));
        end
        @(negedge clk);
        chk("t1_idle", b1(v1), b1(1'b0));

        // Back-to-back A,B with factor 3
        factor = 4'd3; in_data = 24'h111AAA; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) in_data = 24'h222BBB;
            if (i == 3) in_valid = 1'b0;
            chk("t2_m0", pk(v0, d0, p0, l0),
                pk(1'b1, (i < 3) ? 24'h111AAA : 24'h222BBB, 4'(i % 3), (i % 3) == 2));
            chk("t2_m1", pk(v1, d1, p1, l1),
                pk(1'b1, (i == 0) ? 24'h111AAA : ((i == 3) ? 24'h222BBB : 24'd0),
                   4'(i % 3), (i % 3) == 2));
            #1 chk("t2_rdy", b1(rdy0), b1(i == 2 || i == 5));
        end
        @(negedge clk);
        chk("t2_idle", b1(v0), b1(1'b0));

        // Pass-through with factor 0 and 1
        for (int f = 0; f < 2; f++) begin
            factor = 4'(f); in_data = 24'd1; in_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (i < 2) in_data = 24'(i + 2);
                else in_valid = 1'b0;
                chk("t3_m0", pk(v0, d0, p0, l0), pk(1'b1, 24'(i + 1), 4'd0, 1'b1));
                chk("t3_m1", pk(v1, d1, p1, l1), pk(1'b1, 24'(i + 1), 4'd0, 1'b1));
            end
            @(negedge clk);
            chk("t3_idle", b1(v0), b1(1'b0));
        end

        // Reset in the middle of an 8-phase emission
        factor = 4'd8; in_data = 24'h5A5A5A; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("t4_pre", pk(v0, d0, p0, l0), pk(1'b1, 24'h5A5A5A, 4'(i), 1'b0));
        end
        rst = 1'b1;
        #1 chk("t4_rst_rdy", b1(rdy0), b1(1'b0));
        @(negedge clk);
        chk("t4_rst_m0", pk(v0, d0, p0, l0), 32'd0);
        chk("t4_rst_m1", pk(v1, d1, p1, l1), 32'd0);
        rst = 1'b0; in_data = 24'h0F0F0F; in_valid = 1'b1; factor = 4'd8;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("t4_post", pk(v0, d0, p0, l0), pk(1'b1, 24'h0F0F0F, 4'(i), i == 7));
        end
        @(negedge clk);
        chk("t4_idle", b1(v0), b1(1'b0));

        // Random scoreboard: random factor every cycle, random stalls
        sent = 0; beats0 = 0; beats1 = 0; exp_beats = 0; cyc = 0;
        while (cyc < 60000 &&
               !(sent == 1500 && q0.size() == 0 && q1.size() == 0 && !v0 && !v1)) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 1500) && ($urandom_range(0, 9) < 7);
            in_data   = 24'($urandom);
            factor    = 4'($urandom_range(0, 15));
            #1;
            lval = (factor == 4'd0) ? 1 : int'(factor);
            if (in_valid && rdy0) begin
                sent++;
                exp_beats += lval;
                for (int p = 0; p < lval; p++)
                    q0.push_back(pk(1'b1, in_data, 4'(p), p == lval - 1));
            end
            if (in_valid && rdy1) begin
                for (int p = 0; p < lval; p++)
                    q1.push_back(pk(1'b1, (p == 0) ? in_data : 24'd0, 4'(p), p == lval - 1));
            end
            if (v0 && out_ready) begin
                beats0++;
                if (q0.size() == 0) chk("sb0_extra", b1(1'b1), b1(1'b0));
                else begin
                    head = q0.pop_front();
                    chk("sb0", pk(v0, d0, p0, l0), head);
                end
            end
            if (v1 && out_ready) begin
                beats1++;
                if (q1.size() == 0) chk("sb1_extra", b1(1'b1), b1(1'b0));
                else begin
                    head = q1.pop_front();
                    chk("sb1", pk(v1, d1, p1, l1), head);
                end
            end
        end
        chk("sb_timeout", b1(cyc >= 60000), b1(1'b0));
        chk("sb_count0", 32'(beats0), 32'(exp_beats));
        chk("sb_count1", 32'(beats1), 32'(exp_beats));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
